// File: rtl/program_counter_pkg.sv
// ----------------------------------------------------------------------------
// program_counter_pkg
//   Shared CPU definitions used by the program counter and its bus interface.
//   PC_WIDTH   : address width of the CPU, default width of the counter.
//   pc_op_e    : the operation the counter performs on a clock edge.
//   decode_op  : maps the load/increment controls onto pc_op_e with load
//                taking priority over increment.
// ----------------------------------------------------------------------------
package program_counter_pkg;

  localparam int PC_WIDTH = 9;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_op_e;

  // A jump/branch load must never be bumped by a coincident increment, so
  // load is checked first.
  function automatic pc_op_e decode_op(input logic load, input logic inc);
    if (load) return PC_LOAD;
    if (inc)  return PC_INC;
    return PC_HOLD;
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// ----------------------------------------------------------------------------
// program_counter_if
//   Control and bus connection of the program counter.
//   pc_load   : load in_value on the next rising clk edge
//   pc_inc    : increment on the next rising clk edge (when pc_load is low)
//   pc_enOut  : drive the counter onto out_value, else release it
//   in_value  : value to load (WIDTH bits)
//   out_value : shared address/data bus; a resolved net so several sources
//               may drive it while the others are tri-stated
//   Modports: master = control unit side, slave = program counter side.
// ----------------------------------------------------------------------------
interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);

  logic             pc_load;
  logic             pc_inc;
  logic             pc_enOut;
  logic [WIDTH-1:0] in_value;
  wire  [WIDTH-1:0] out_value;

  modport master (
    output pc_load,
    output pc_inc,
    output pc_enOut,
    output in_value,
    input  out_value
  );

  modport slave (
    input  pc_load,
    input  pc_inc,
    input  pc_enOut,
    input  in_value,
    output out_value
  );

endinterface

// File: rtl/program_counter_bus_driver.sv
// ----------------------------------------------------------------------------
// program_counter_bus_driver
//   Tri-state driver for a shared bus; reusable by any bus source.
//   en : 1 drives d onto q, 0 releases q (all bits Z)
//   d  : value to drive (WIDTH bits)
//   q  : bus connection (WIDTH bits)
// ----------------------------------------------------------------------------
module program_counter_bus_driver #(
  parameter int WIDTH = 9
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output wire  [WIDTH-1:0] q
);

  assign q = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/program_counter.sv
// ----------------------------------------------------------------------------
// program_counter
//   Program counter register of the CPU datapath: holds the address of the
//   current instruction, supports a parallel load (jumps/branches) and a +1
//   increment (sequential fetch), and drives the shared bus when enabled.
//   clk   : system clock, all updates on the rising edge
//   reset : asynchronous, active-high; clears the counter immediately
//   bus   : program_counter_if.slave (pc_load, pc_inc, pc_enOut, in_value,
//           out_value)
// ----------------------------------------------------------------------------
module program_counter
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  program_counter_if.slave   bus
);

  logic [WIDTH-1:0] pc;
  pc_op_e           op;

  always_comb begin
    op = decode_op(bus.pc_load, bus.pc_inc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      unique case (op)
        PC_LOAD: pc <= bus.in_value;
        PC_INC:  pc <= pc + 1'b1;  // all-ones wraps to zero
        default: pc <= pc;
      endcase
    end
  end

  // The bus output is purely combinational so enabling or releasing the bus
  // never disturbs the stored count.
  program_counter_bus_driver #(
    .WIDTH (WIDTH)
  ) u_bus_driver (
    .en (bus.pc_enOut),
    .d  (pc),
    .q  (bus.out_value)
  );

endmodule

// File: tb/tb_program_counter.sv
// ----------------------------------------------------------------------------
// tb_program_counter
//   Directed, self-checking bench for program_counter. A second bus source
//   lives on out_value so that releasing the bus is observable: while the
//   counter is disabled, the bench's own value must appear unchanged.
// ----------------------------------------------------------------------------
module tb_program_counter;
  import program_counter_pkg::*;

  localparam int W = PC_WIDTH;

  logic         clk;
  logic         reset;
  logic         tb_drv_en;
  logic [W-1:0] tb_drv_val;

  int tests_run;
  int tests_failed;

  program_counter_if #(.WIDTH(W)) bus ();

  program_counter #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Competing bus source, only active while the counter should be released.
  assign bus.out_value = tb_drv_en ? tb_drv_val : {W{1'bz}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    tb_drv_en    = 1'b0;
    tb_drv_val   = '0;
    bus.pc_load  = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_enOut = 1'b1;
    bus.in_value = '0;

    // Asynchronous reset before any clock edge (first posedge is at t=5).
    #2 reset = 1'b1;
    #1 check("reset_async", bus.out_value, 9'h000);
    @(negedge clk);
    reset = 1'b0;

    // Load, then hold.
    bus.in_value = 9'b111001100;
    bus.pc_load  = 1'b1;
    tick();
    check("load", bus.out_value, 9'b111001100);
    bus.pc_load = 1'b0;
    tick();
    check("load_hold", bus.out_value, 9'b111001100);

    // Increment, then hold.
    bus.pc_inc = 1'b1;
    tick();
    check("inc", bus.out_value, 9'b111001101);
    bus.pc_inc = 1'b0;
    tick();
    check("inc_hold", bus.out_value, 9'b111001101);

    // Wrap from all-ones.
    bus.in_value = 9'h1FF;
    bus.pc_load  = 1'b1;
    tick();
    check("load_1ff", bus.out_value, 9'h1FF);
    bus.pc_load = 1'b0;
    bus.pc_inc  = 1'b1;
    tick();
    check("wrap", bus.out_value, 9'h000);

    // Load beats increment, and the loaded value is not bumped.
    bus.in_value = 9'h055;
    bus.pc_load  = 1'b1;
    bus.pc_inc   = 1'b1;
    tick();
    check("priority", bus.out_value, 9'h055);
    bus.pc_load  = 1'b0;
    bus.in_value = 9'h000;
    tick();
    check("inc_after_prio", bus.out_value, 9'h056);
    bus.pc_inc = 1'b0;

    // Output enable: released bus shows the other source, pc unaffected.
    bus.in_value = 9'h0AA;
    bus.pc_load  = 1'b1;
    tick();
    bus.pc_load = 1'b0;
    check("load_0aa", bus.out_value, 9'h0AA);
    bus.pc_enOut = 1'b0;
    tb_drv_val   = 9'h155;
    tb_drv_en    = 1'b1;
    #1 check("oe_released", bus.out_value, 9'h155);
    tick();
    tick();
    tb_drv_en    = 1'b0;
    bus.pc_enOut = 1'b1;
    #1 check("oe_restore", bus.out_value, 9'h0AA);
    @(negedge clk);

    // Count to 3, then reset between edges with controls still active.
    bus.in_value = 9'h000;
    bus.pc_load  = 1'b1;
    tick();
    bus.pc_load = 1'b0;
    bus.pc_inc  = 1'b1;
    tick();
    tick();
    tick();
    check("count3", bus.out_value, 9'h003);
    reset = 1'b1;
    #1 check("async_mid", bus.out_value, 9'h000);
    tick();
    tick();
    check("reset_hold_inc", bus.out_value, 9'h000);
    bus.in_value = 9'h1FF;
    bus.pc_load  = 1'b1;
    tick();
    check("reset_hold_load", bus.out_value, 9'h000);

    // Leave reset and resume counting from zero.
    bus.pc_load = 1'b0;
    reset       = 1'b0;
    tick();
    check("post_reset_inc", bus.out_value, 9'h001);
    bus.pc_inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
